div_share_arb: RTL and testbench
================================

# div_share_arb

Shares one instance of the team's sequential fixed-point divider among NREQ requesters. Typical requesters are the average-pool normaliser and the SE-block scale path. Each requester presents a signed Q(WIDTH-FBITS).FBITS dividend and a positive integer divisor with a valid/ready handshake. The block grants one request at a time, sequences the divider's start/done protocol, and returns the quotient with a one-hot response strobe and an error flag.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 14, dividend/quotient width (signed, incl. FBITS fraction bits)
- FBITS, 7, fractional bits of dividend and quotient
- BWIDTH, 12, divisor width (signed integer, positive in use)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*BWIDTH  divisors, requester i at [i*BWIDTH +: BWIDTH]
- resp_valid  out  NREQ  one-hot, one-cycle result strobe to the owning requester
- resp_val  out  WIDTH  quotient, valid while any resp_valid bit is high
- resp_err  out  1  divide-by-zero/overflow indication, qualified by resp_valid
- arb_busy  out  1  high from accept until resp_valid is issued

## Operation
- The FSM has four states: IDLE, START, WAIT and RESP.
- IDLE: if any req_valid is set, pick grant g.
  - Assert req_ready[g] combinationally in that cycle.
  - Latch req_a[g], req_b[g] and g into operand/owner registers.
  - Go to START.
- START: drive div start=1 for exactly one cycle with the latched operands, then go to WAIT.
- WAIT: hold the operands stable; the divider reads the dividend sign late in its operation.
  - Track busy_seen, which is set if div busy is observed high.
  - On div done, latch val into resp_val and set resp_err = ~busy_seen.
  - Go to RESP.
- RESP: resp_valid[owner]=1 for one cycle, clear arb_busy, return to IDLE.
  - A new grant can be made in the following cycle, not in the RESP cycle itself.
- Default arbitration is round-robin.
  - A pointer holds the index that has highest priority next.
  - The search runs pointer, pointer+1, ... modulo NREQ.
  - After a grant to g, pointer = (g+1) mod NREQ. The pointer resets to 0.
- Operands are forwarded unchanged. Divider semantics:
  - b==0, a==most-negative, or b==most-negative produce val = all ones through the divider fast path. This is reported as resp_err=1.
  - Otherwise the quotient is rounded to nearest, half up in magnitude.
- A requester must hold req_valid and its operands until it sees req_ready. The block never accepts two requests in the same cycle.

## Timing
- Reset values:
  - Outputs: req_ready=0, resp_valid=0, resp_val=0, resp_err=0, arb_busy=0.
  - Internal: state=IDLE, pointer=0.
- Reset is shared with the divider instance. Reset asserted mid-operation drops the in-flight request and issues no response.
- The accept cycle is A.
  - Normal path (default parameters, ITER = WIDTH+FBITS = 21): start at A+1, done at A+26, resp_valid at A+27.
  - Fast path (error): done at A+3, resp_valid at A+4.
- Sustained throughput is one request per 28 cycles for the normal path.
- Simultaneous req_valid from all requesters while arb_busy is high: all are held off with req_ready=0, and none is lost.
- req_valid withdrawn before being granted has no effect.

## Configuration
- DIV_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest-index valid requester always wins, and the pointer logic is removed.
- DIV_ARB_FIXED_PRIO_EN undefined: round-robin as described above.

## Structure
- Package div_arb_pkg holds:
  - the state encoding (IDLE/START/WAIT/RESP);
  - the default NREQ;
  - the divider latency constant (ITER+4) used by the bench;
  - a clog2-based owner-ID width helper.
- One sub-module: the existing divider `div`, instantiated once with WIDTH/FBITS/BWIDTH passed through. Arbitration is inline.

## Test plan
- Requester 1, a=384 (3.0), b=3 -> resp_valid=4'b0010 at A+27, resp_val=128 (1.0), resp_err=0.
- Requester 0, a=-384 (14'h3E80), b=3 -> resp_val=14'h3F80 (-1.0), resp_err=0.
- Requester 2, a=256, b=0 -> resp_valid=4'b0100 at A+4, resp_val=14'h3FFF, resp_err=1.
- All four req_valid held high for 5 grants -> grant order 0,1,2,3,0. With DIV_ARB_FIXED_PRIO_EN the order is 0,0,0,0,0.
- Assert rst during WAIT (cycle A+10) -> no resp_valid ever issues, all outputs 0. A fresh request a=640, b=5 then returns 128.
- Request with a=100 (0.78125), b=7 -> resp_val=14 (0.109375, rounded from 14.28), resp_err=0.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter and its divider.
package div_arb_pkg;

    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned WIDTH_DEF  = 14;
    localparam int unsigned FBITS_DEF  = 7;
    localparam int unsigned BWIDTH_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    typedef enum logic [2:0] {
        DV_IDLE,
        DV_FAST,
        DV_PREP,
        DV_ITER,
        DV_ROUND,
        DV_SIGN
    } div_state_e;

    // Cycles from the divider start pulse to its done pulse (normal path).
    function automatic int unsigned div_latency(input int unsigned width, input int unsigned fbits);
        return width + fbits + 4;
    endfunction

    localparam int unsigned DIV_LATENCY = div_latency(WIDTH_DEF, FBITS_DEF);

    function automatic int unsigned owner_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_share_arb_div.sv
// Sequential fixed-point divider: signed Q dividend / signed integer divisor,
// restoring division with round-half-up in magnitude, start/busy/done handshake.
module div
    import div_arb_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned FBITS  = FBITS_DEF,
    parameter int unsigned BWIDTH = BWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [BWIDTH-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  val
);

    localparam int unsigned ITER = WIDTH + FBITS;
    localparam int unsigned CW   = $clog2(ITER + 1);

    div_state_e         st_q, st_d;
    logic [WIDTH-1:0]   a_cap_q, a_cap_d;
    logic [BWIDTH-1:0]  b_cap_q, b_cap_d;
    logic [ITER-1:0]    num_q, num_d;
    logic [BWIDTH-1:0]  rem_q, rem_d;
    logic [BWIDTH-1:0]  bmag_q, bmag_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   qmag_q, qmag_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   amag;
    logic [BWIDTH-1:0]  bmag_c;
    logic [BWIDTH:0]    rem_sh;
    logic [BWIDTH:0]    diff;
    logic [ITER:0]      rnd;
    logic               fast;

    always_comb begin
        st_d    = st_q;
        a_cap_d = a_cap_q;
        b_cap_d = b_cap_q;
        num_d   = num_q;
        rem_d   = rem_q;
        bmag_d  = bmag_q;
        cnt_d   = cnt_q;
        qmag_d  = qmag_q;
        val_d   = val_q;
        done_d  = 1'b0;

        amag   = a_cap_q[WIDTH-1] ? (~a_cap_q + 1'b1) : a_cap_q;
        bmag_c = b_cap_q[BWIDTH-1] ? (~b_cap_q + 1'b1) : b_cap_q;
        rem_sh = {rem_q, num_q[ITER-1]};
        diff   = rem_sh - {1'b0, bmag_q};
        rnd    = {1'b0, num_q} + (ITER+1)'(1 << (FBITS - 1));
        fast   = (b == '0) || (a == {1'b1, {(WIDTH-1){1'b0}}})
              || (b == {1'b1, {(BWIDTH-1){1'b0}}});

        case (st_q)
            DV_IDLE: begin
                if (start) begin
                    a_cap_d = a;
                    b_cap_d = b;
                    st_d    = fast ? DV_FAST : DV_PREP;
                end
            end
            DV_FAST: begin
                val_d  = '1;
                done_d = 1'b1;
                st_d   = DV_IDLE;
            end
            DV_PREP: begin
                num_d  = {amag, {FBITS{1'b0}}};
                bmag_d = bmag_c;
                rem_d  = '0;
                cnt_d  = CW'(ITER);
                st_d   = DV_ITER;
            end
            DV_ITER: begin
                if (rem_sh >= {1'b0, bmag_q}) begin
                    rem_d = diff[BWIDTH-1:0];
                    num_d = {num_q[ITER-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[BWIDTH-1:0];
                    num_d = {num_q[ITER-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    st_d = DV_ROUND;
                end
            end
            DV_ROUND: begin
                qmag_d = rnd[FBITS +: WIDTH];
                st_d   = DV_SIGN;
            end
            DV_SIGN: begin
                // Dividend sign comes straight from the port here, so the
                // caller must hold its operand until done.
                val_d  = (a[WIDTH-1] ^ b_cap_q[BWIDTH-1]) ? (~qmag_q + 1'b1) : qmag_q;
                done_d = 1'b1;
                st_d   = DV_IDLE;
            end
            default: st_d = DV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= DV_IDLE;
            a_cap_q <= '0;
            b_cap_q <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            cnt_q   <= '0;
            qmag_q  <= '0;
            val_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            a_cap_q <= a_cap_d;
            b_cap_q <= b_cap_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            bmag_q  <= bmag_d;
            cnt_q   <= cnt_d;
            qmag_q  <= qmag_d;
            val_q   <= val_d;
            done_q  <= done_d;
        end
    end

    assign busy = (st_q == DV_PREP) || (st_q == DV_ITER)
               || (st_q == DV_ROUND) || (st_q == DV_SIGN);
    assign done = done_q;
    assign val  = val_q;

endmodule

// File: rtl/div_share_arb.sv
// Shares one sequential divider among NREQ requesters (round-robin grant).
// Define DIV_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module div_share_arb
    import div_arb_pkg::*;
#(
    parameter int unsigned NREQ   = NREQ_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned FBITS  = FBITS_DEF,
    parameter int unsigned BWIDTH = BWIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*BWIDTH-1:0]   req_b,
    output logic [NREQ-1:0]          resp_valid,
    output logic [WIDTH-1:0]         resp_val,
    output logic                     resp_err,
    output logic                     arb_busy
);

    localparam int unsigned OW = owner_w(NREQ);

    arb_state_e         st_q, st_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [BWIDTH-1:0]  b_q, b_d;
    logic [NREQ-1:0]    resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   resp_val_q, resp_val_d;
    logic               resp_err_q, resp_err_d;
    logic               arb_busy_q, arb_busy_d;
    logic               busy_seen_q, busy_seen_d;

    logic               grant_ok;
    logic [OW-1:0]      grant_idx;
    logic [WIDTH-1:0]   sel_a;
    logic [BWIDTH-1:0]  sel_b;

    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [WIDTH-1:0]   div_val;

`ifndef DIV_ARB_FIXED_PRIO_EN
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [OW:0]        cand;
    logic [OW:0]        ptr_inc;
`endif

    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
`ifdef DIV_ARB_FIXED_PRIO_EN
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_ok && req_valid[k]) begin
                grant_ok  = 1'b1;
                grant_idx = OW'(k);
            end
        end
`else
        cand = '0;
        // Search from the pointer upward, wrapping at NREQ (need not be 2^n).
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (OW+1)'(k);
            if (cand >= (OW+1)'(NREQ)) begin
                cand = cand - (OW+1)'(NREQ);
            end
            if (!grant_ok && req_valid[cand[OW-1:0]]) begin
                grant_ok  = 1'b1;
                grant_idx = cand[OW-1:0];
            end
        end
`endif
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_idx == OW'(k)) begin
                sel_a = req_a[k*WIDTH +: WIDTH];
                sel_b = req_b[k*BWIDTH +: BWIDTH];
            end
        end
    end

    always_comb begin
        st_d         = st_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_valid_d = '0;
        resp_val_d   = resp_val_q;
        resp_err_d   = resp_err_q;
        arb_busy_d   = arb_busy_q;
        busy_seen_d  = busy_seen_q;
        req_ready    = '0;
`ifndef DIV_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
        ptr_inc = {1'b0, grant_idx} + (OW+1)'(1);
`endif

        case (st_q)
            ST_IDLE: begin
                if (grant_ok && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    a_d        = sel_a;
                    b_d        = sel_b;
                    owner_d    = grant_idx;
                    arb_busy_d = 1'b1;
                    st_d       = ST_START;
`ifndef DIV_ARB_FIXED_PRIO_EN
                    ptr_d = (ptr_inc >= (OW+1)'(NREQ)) ? '0 : ptr_inc[OW-1:0];
`endif
                end
            end
            ST_START: begin
                busy_seen_d = 1'b0;
                st_d        = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_busy) begin
                    busy_seen_d = 1'b1;
                end
                // The divider's fast path never raises busy; that marks an error.
                if (div_done) begin
                    resp_val_d             = div_val;
                    resp_err_d             = ~busy_seen_q;
                    resp_valid_d[owner_q]  = 1'b1;
                    arb_busy_d             = 1'b0;
                    st_d                   = ST_RESP;
                end
            end
            ST_RESP: begin
                st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= ST_IDLE;
            owner_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_valid_q <= '0;
            resp_val_q   <= '0;
            resp_err_q   <= 1'b0;
            arb_busy_q   <= 1'b0;
            busy_seen_q  <= 1'b0;
`ifndef DIV_ARB_FIXED_PRIO_EN
            ptr_q        <= '0;
`endif
        end else begin
            st_q         <= st_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_valid_q <= resp_valid_d;
            resp_val_q   <= resp_val_d;
            resp_err_q   <= resp_err_d;
            arb_busy_q   <= arb_busy_d;
            busy_seen_q  <= busy_seen_d;
`ifndef DIV_ARB_FIXED_PRIO_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign div_start = (st_q == ST_START);

    div #(
        .WIDTH  (WIDTH),
        .FBITS  (FBITS),
        .BWIDTH (BWIDTH)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .a     (a_q),
        .b     (b_q),
        .busy  (div_busy),
        .done  (div_done),
        .val   (div_val)
    );

    assign resp_valid = resp_valid_q;
    assign resp_val   = resp_val_q;
    assign resp_err   = resp_err_q;
    assign arb_busy   = arb_busy_q;

endmodule

// File: tb/tb_div_share_arb.sv
// Directed bench for div_share_arb with an expected-response scoreboard.
module tb_div_share_arb;
    import div_arb_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 14;
    localparam int unsigned F    = 7;
    localparam int unsigned BW   = 12;
    localparam int LAT_OK  = int'(DIV_LATENCY) + 2;
    localparam int LAT_ERR = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a = '0;
    logic [NREQ*BW-1:0]   req_b = '0;
    logic [NREQ-1:0]      resp_valid;
    logic [W-1:0]         resp_val;
    logic                 resp_err;
    logic                 arb_busy;

    typedef struct {
        int         owner;
        logic [W-1:0] val;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   acc_cnt = 0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    div_share_arb #(
        .NREQ   (NREQ),
        .WIDTH  (W),
        .FBITS  (F),
        .BWIDTH (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_val   (resp_val),
        .resp_err   (resp_err),
        .arb_busy   (arb_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: round-half-up of |a|/|b| via integer (2|a|+|b|)/(2|b|).
    function automatic logic [W:0] ref_div(input logic [W-1:0] a, input logic [BW-1:0] b);
        int ai, bi, am, bm, q;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0 || a == 14'h2000 || b == 12'h800) return {1'b1, {W{1'b1}}};
        am = (ai < 0) ? -ai : ai;
        bm = (bi < 0) ? -bi : bi;
        q  = (2 * am + bm) / (2 * bm);
        if ((ai < 0) != (bi < 0)) q = -q;
        return {1'b0, W'(q)};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [W:0] r;
        if (!rst) begin
            if (req_ready != '0) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        chk("ready_has_valid", 32'(req_valid[i]), 32'd1);
                        r = ref_div(req_a[i*W +: W], req_b[i*BW +: BW]);
                        e.owner = i;
                        e.val   = r[W-1:0];
                        e.err   = r[W];
                        e.due   = cyc + (r[W] ? LAT_ERR : LAT_OK);
                        sb.push_back(e);
                        grant_log.push_back(i);
                        acc_cnt++;
                    end
                end
            end
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner", 32'(resp_valid), 32'(1 << e.owner));
                    chk("resp_val", 32'(resp_val), 32'(e.val));
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("resp_cycle", 32'(cyc), 32'(e.due));
                    chk("busy_clear_at_resp", 32'(arb_busy), 32'd0);
                end
            end
        end
    end

    task automatic do_req(input int i, input logic [W-1:0] a, input logic [BW-1:0] b,
                          output int acc_cyc);
        int n;
        n = 0;
        req_a[i*W +: W]   = a;
        req_b[i*BW +: BW] = b;
        req_valid[i]      = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 100);
        if (!req_ready[i]) chk("accept_timeout", 32'(req_ready[i]), 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (acc_cnt < target) chk("grant_timeout", 32'(acc_cnt), 32'(target));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_val"}, 32'(resp_val), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_busy"}, 32'(arb_busy), 32'd0);
    endtask

    initial begin
        int t, t2, base;
        int exp_order;

        req_valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // All four requesters held valid for five grants.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W]   = W'((i + 1) * 256);
            req_b[i*BW +: BW] = BW'(2);
        end
        base = acc_cnt;
        req_valid = '1;
        wait_acc(base + 1, 10);
        repeat (5) @(negedge clk);
        chk("holdoff_ready", 32'(req_ready), 32'd0);
        chk("holdoff_busy", 32'(arb_busy), 32'd1);
        wait_acc(base + 5, 200);
        @(posedge clk);
        #1 req_valid = '0;
        chk("rr_count", 32'(acc_cnt - base), 32'd5);
        for (int k = 0; k < 5; k++) begin
`ifdef DIV_ARB_FIXED_PRIO_EN
            exp_order = 0;
`else
            exp_order = k % NREQ;
`endif
            if (base + k < grant_log.size()) chk("rr_order", 32'(grant_log[base+k]), 32'(exp_order));
        end
        wait_idle(200);

        do_req(1, 14'd384, 12'd3, t);
        @(negedge clk);
        chk("busy_after_accept", 32'(arb_busy), 32'd1);
        wait_idle(60);

        do_req(0, 14'h3E80, 12'd3, t);
        wait_idle(60);
        do_req(2, 14'd256, 12'd0, t);
        wait_idle(60);
        do_req(3, 14'd100, 12'd7, t);
        wait_idle(60);
        do_req(0, 14'd100, 12'h800, t);
        wait_idle(60);
        do_req(1, 14'h2000, 12'd3, t);
        wait_idle(60);
        do_req(2, 14'h3F00, 12'd6, t);
        wait_idle(60);

        // Back-to-back from one requester sets the sustained rate.
        do_req(1, 14'd384, 12'd3, t);
        do_req(1, 14'd640, 12'd5, t2);
        chk("throughput", 32'(t2 - t), 32'd28);
        wait_idle(60);

        // Reset during WAIT drops the in-flight request.
        do_req(2, 14'd384, 12'd3, t);
        while (cyc < t + 10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1 chk_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_reset_resp", 32'(resp_valid), 32'd0);
        chk("post_reset_busy", 32'(arb_busy), 32'd0);
        do_req(0, 14'd640, 12'd5, t);
        wait_idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
